// File: rtl/lpc_consts.sv
`default_nettype none
// ============================================================================
// Module      : lpc_consts (package)
// Description : Constants and state encodings shared by the A(z)-to-LSP FSMs.
//               Holds the LP order, the half-order loop count, the Q11 unity
//               and Q15 one-half operands, the default scratch base address
//               of a[0], and the 4-bit state encoding of the sum/difference
//               polynomial builder.
// Revision    : 1.0 - initial release
// ============================================================================
package lpc_consts;

  // LP order and number of sum/difference iterations (M/2)
  localparam int          c_LPC_M       = 10;
  localparam int          c_LPC_NC      = 5;

  // Scratch-memory address of a[0]
  localparam logic [11:0] c_A_BASE_DFLT = 12'd0;

  // 1.0 in Q11 (seed of f1[0] / f2[0]) and 0.5 in Q15 (halving multiplier)
  localparam logic [15:0] c_Q11_ONE     = 16'd2048;
  localparam logic [15:0] c_Q15_HALF    = 16'd16384;

  // State encoding of the sum/difference polynomial builder
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RD1  = 4'd1,
    S_RD2  = 4'd2,
    S_F1   = 4'd3,
    S_F2   = 4'd4,
    S_DONE = 4'd5
  } state_t;

endpackage : lpc_consts
`default_nettype wire

// File: rtl/coeff_regfile_6x16.sv
`default_nettype none
// ============================================================================
// Module      : coeff_regfile_6x16
// Description : Six-entry, 16-bit coefficient register bank with synchronous
//               reset, a whole-bank clear and one write port. All entries are
//               visible at once on a packed 96-bit read bus.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset (all entries to 0)
//               i_clr    - clear every entry (a same-cycle write wins on its
//                          own entry, so clear+write seeds entry 0 in one go)
//               i_we     - write enable
//               i_idx    - write index 0..5
//               i_wdata  - write data
//               o_rdata  - entry k at bits [16k+15:16k]
// Revision    : 1.0 - initial release
// ============================================================================
module coeff_regfile_6x16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_we,
  input  logic [2:0]  i_idx,
  input  logic [15:0] i_wdata,
  output logic [95:0] o_rdata
);

  localparam int c_ENTRIES = 6;

  generate
    for (genvar g = 0; g < c_ENTRIES; g++) begin : g_entry
      logic [15:0] r_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else if (i_we && (i_idx == 3'(g))) begin
          r_q <= i_wdata;
        end else if (i_clr) begin
          r_q <= '0;
        end
      end

      assign o_rdata[16*g +: 16] = r_q;
    end
  endgenerate

endmodule : coeff_regfile_6x16
`default_nettype wire

// File: rtl/az_sum_diff_poly.sv
`default_nettype none
// ============================================================================
// Module      : az_sum_diff_poly
// Description : Builds the G.729 sum polynomial F1 and difference polynomial
//               F2 (Q11, halved) from the 10th-order LP coefficients a[1..10]
//               held in scratch memory. For i = 0..4:
//                 x1 = (a[i+1] + a[M-i]) / 2   ->  f1[i+1] = x1 - f1[i]
//                 x2 = (a[i+1] - a[M-i]) / 2   ->  f2[i+1] = x2 + f2[i]
//               with f1[0] = f2[0] = 1.0 (Q11). All arithmetic, including
//               saturation, is done by the shared external basic-op units;
//               this block only sequences, slices and routes.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start               - begin a computation (IDLE only)
//               aAddr / aData       - scratch read port (1-cycle latency)
//               L_mult*, L_mac*,
//               L_msu*, add*, sub*  - external basic-op operands/results
//               f1Out / f2Out       - f1[k] / f2[k] at bits [16k+15:16k]
//               done                - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module az_sum_diff_poly
  import lpc_consts::*;
#(
  parameter int          M      = c_LPC_M,
  parameter int          NC     = c_LPC_NC,
  parameter logic [11:0] A_BASE = c_A_BASE_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [11:0] aAddr,
  input  logic [15:0] aData,
  output logic [15:0] L_multOutA,
  output logic [15:0] L_multOutB,
  input  logic [31:0] L_multIn,
  output logic [15:0] L_macOutA,
  output logic [15:0] L_macOutB,
  output logic [31:0] L_macOutC,
  input  logic [31:0] L_macIn,
  output logic [15:0] L_msuOutA,
  output logic [15:0] L_msuOutB,
  output logic [31:0] L_msuOutC,
  input  logic [31:0] L_msuIn,
  output logic [15:0] addOutA,
  output logic [15:0] addOutB,
  input  logic [15:0] addIn,
  output logic [15:0] subOutA,
  output logic [15:0] subOutB,
  input  logic [15:0] subIn,
  output logic [95:0] f1Out,
  output logic [95:0] f2Out,
  output logic        done
);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [2:0]  r_i;      // loop index, 0..NC-1
  logic [15:0] r_ahi;    // a[i+1]
  logic [15:0] r_alo;    // a[M-i]
  logic        r_done;

  // --------------------------------------------------------------------------
  // Combinational datapath controls
  // --------------------------------------------------------------------------
  logic        w_clr;
  logic        w_f1_we;
  logic        w_f2_we;
  logic [2:0]  w_wr_idx;
  logic [15:0] w_f1_wdata;
  logic [15:0] w_f2_wdata;
  logic [15:0] w_x1;
  logic [15:0] w_x2;
  logic [15:0] w_f1_cur;
  logic [15:0] w_f2_cur;
  logic [95:0] w_f1_all;
  logic [95:0] w_f2_all;
  logic [2:0]  w_i_next;

  // Only the high halves of the 32-bit accumulator results are used (Q15
  // halving folds into taking bits [31:16]).
  logic        w_unused;
  assign w_unused = ^{L_macIn[15:0], L_msuIn[15:0]};

  assign w_i_next = r_i + 3'd1;

  // Current f1[i] / f2[i]; r_i never exceeds NC-1 in the states that use it.
  assign w_f1_cur = w_f1_all[{r_i, 4'b0000} +: 16];
  assign w_f2_cur = w_f2_all[{r_i, 4'b0000} +: 16];

  always_comb begin
    aAddr      = '0;
    L_multOutA = '0;
    L_multOutB = '0;
    L_macOutA  = '0;
    L_macOutB  = '0;
    L_macOutC  = '0;
    L_msuOutA  = '0;
    L_msuOutB  = '0;
    L_msuOutC  = '0;
    addOutA    = '0;
    addOutB    = '0;
    subOutA    = '0;
    subOutB    = '0;
    w_clr      = 1'b0;
    w_f1_we    = 1'b0;
    w_f2_we    = 1'b0;
    w_wr_idx   = w_i_next;
    w_f1_wdata = '0;
    w_f2_wdata = '0;
    w_x1       = '0;
    w_x2       = '0;

    case (r_state)
      S_IDLE: begin
        // Clear both banks and seed entry 0 with 1.0 in the same cycle
        if (start) begin
          w_clr      = 1'b1;
          w_f1_we    = 1'b1;
          w_f2_we    = 1'b1;
          w_wr_idx   = 3'd0;
          w_f1_wdata = c_Q11_ONE;
          w_f2_wdata = c_Q11_ONE;
        end
      end

      S_RD1: begin
        aAddr = A_BASE + 12'(r_i) + 12'd1;
      end

      S_RD2: begin
        aAddr = A_BASE + 12'(M) - 12'(r_i);
      end

      S_F1: begin
        // aData here is a[M-i]; x1 = hi(a[i+1]*0.5 + a[M-i]*0.5)
        L_multOutA = r_ahi;
        L_multOutB = c_Q15_HALF;
        L_macOutC  = L_multIn;
        L_macOutA  = aData;
        L_macOutB  = c_Q15_HALF;
        w_x1       = L_macIn[31:16];
        subOutA    = w_x1;
        subOutB    = w_f1_cur;
        w_f1_we    = 1'b1;
        w_f1_wdata = subIn;
      end

      S_F2: begin
        // x2 = hi(a[i+1]*0.5 - a[M-i]*0.5)
        L_multOutA = r_ahi;
        L_multOutB = c_Q15_HALF;
        L_msuOutC  = L_multIn;
        L_msuOutA  = r_alo;
        L_msuOutB  = c_Q15_HALF;
        w_x2       = L_msuIn[31:16];
        addOutA    = w_x2;
        addOutB    = w_f2_cur;
        w_f2_we    = 1'b1;
        w_f2_wdata = addIn;
      end

      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_ahi   <= '0;
      r_alo   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i     <= '0;
            r_state <= S_RD1;
          end
        end
        S_RD1: begin
          r_state <= S_RD2;
        end
        S_RD2: begin
          r_ahi   <= aData;
          r_state <= S_F1;
        end
        S_F1: begin
          r_alo   <= aData;
          r_state <= S_F2;
        end
        S_F2: begin
          r_i <= w_i_next;
          if (w_i_next == 3'(NC)) begin
            // done is registered so it is high exactly while in DONE
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_RD1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign done = r_done;

  // --------------------------------------------------------------------------
  // Coefficient banks
  // --------------------------------------------------------------------------
  coeff_regfile_6x16 u_f1_bank (
    .clk     (clk),
    .rst     (reset),
    .i_clr   (w_clr),
    .i_we    (w_f1_we),
    .i_idx   (w_wr_idx),
    .i_wdata (w_f1_wdata),
    .o_rdata (w_f1_all)
  );

  coeff_regfile_6x16 u_f2_bank (
    .clk     (clk),
    .rst     (reset),
    .i_clr   (w_clr),
    .i_we    (w_f2_we),
    .i_idx   (w_wr_idx),
    .i_wdata (w_f2_wdata),
    .o_rdata (w_f2_all)
  );

  assign f1Out = w_f1_all;
  assign f2Out = w_f2_all;

endmodule : az_sum_diff_poly
`default_nettype wire

// File: tb/tb_az_sum_diff_poly.sv
`default_nettype none
// ============================================================================
// Module      : tb_az_sum_diff_poly
// Description : Self-checking bench for az_sum_diff_poly. Provides the scratch
//               memory and the saturating basic-op units, computes expected
//               f1/f2 from the G.729 sum/difference recurrence and compares
//               them when done fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_az_sum_diff_poly;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] aAddr;
  logic [15:0] aData;
  logic [15:0] L_multOutA, L_multOutB;
  logic [31:0] L_multIn;
  logic [15:0] L_macOutA, L_macOutB;
  logic [31:0] L_macOutC, L_macIn;
  logic [15:0] L_msuOutA, L_msuOutB;
  logic [31:0] L_msuOutC, L_msuIn;
  logic [15:0] addOutA, addOutB, addIn;
  logic [15:0] subOutA, subOutB, subIn;
  logic [95:0] f1Out, f2Out;
  logic        done;

  int n_tests;
  int n_fail;

  logic [15:0] mem [0:4095];
  logic [95:0] q_f1 [$];
  logic [95:0] q_f2 [$];

  az_sum_diff_poly dut (
    .clk(clk), .reset(reset), .start(start),
    .aAddr(aAddr), .aData(aData),
    .L_multOutA(L_multOutA), .L_multOutB(L_multOutB), .L_multIn(L_multIn),
    .L_macOutA(L_macOutA), .L_macOutB(L_macOutB), .L_macOutC(L_macOutC), .L_macIn(L_macIn),
    .L_msuOutA(L_msuOutA), .L_msuOutB(L_msuOutB), .L_msuOutC(L_msuOutC), .L_msuIn(L_msuIn),
    .addOutA(addOutA), .addOutB(addOutB), .addIn(addIn),
    .subOutA(subOutA), .subOutB(subOutB), .subIn(subIn),
    .f1Out(f1Out), .f2Out(f2Out), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- basic ops (saturating, G.729 semantics) ----------------
  function automatic logic [31:0] sat32(input longint v);
    if (v > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (v < -64'sh80000000) return 32'h80000000;
    return v[31:0];
  endfunction

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [31:0] lmult(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b)) * 2;
    return sat32(p);
  endfunction

  function automatic logic [31:0] lmac(input logic [31:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = lmult(a, b);
    return sat32(longint'($signed(c)) + longint'($signed(p)));
  endfunction

  function automatic logic [31:0] lmsu(input logic [31:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = lmult(a, b);
    return sat32(longint'($signed(c)) - longint'($signed(p)));
  endfunction

  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
    return sat16(int'($signed(a)) + int'($signed(b)));
  endfunction

  function automatic logic [15:0] sub16(input logic [15:0] a, input logic [15:0] b);
    return sat16(int'($signed(a)) - int'($signed(b)));
  endfunction

  always_comb begin
    L_multIn = lmult(L_multOutA, L_multOutB);
    L_macIn  = lmac(L_macOutC, L_macOutA, L_macOutB);
    L_msuIn  = lmsu(L_msuOutC, L_msuOutA, L_msuOutB);
    addIn    = add16(addOutA, addOutB);
    subIn    = sub16(subOutA, subOutB);
  end

  // Scratch memory, one-cycle read latency
  always @(posedge clk) aData <= mem[aAddr];

  // ---------------- reference model ----------------
  task automatic push_expected();
    logic [15:0] f1 [0:5];
    logic [15:0] f2 [0:5];
    logic [31:0] t, acc;
    logic [15:0] x;
    logic [95:0] e1, e2;
    f1[0] = 16'd2048;
    f2[0] = 16'd2048;
    for (int i = 0; i < 5; i++) begin
      t   = lmult(mem[i+1], 16'd16384);
      acc = lmac(t, mem[10-i], 16'd16384);
      x   = acc[31:16];
      f1[i+1] = sub16(x, f1[i]);
      acc = lmsu(t, mem[10-i], 16'd16384);
      x   = acc[31:16];
      f2[i+1] = add16(x, f2[i]);
    end
    for (int k = 0; k < 6; k++) begin
      e1[16*k +: 16] = f1[k];
      e2[16*k +: 16] = f2[k];
    end
    q_f1.push_back(e1);
    q_f2.push_back(e2);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 11; k++) mem[k] = 16'h0000;
  endtask

  // Pulse start; returns #1 after the edge that samples it (cycle +1).
  task automatic kick();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle n = 1 is the first cycle after start is sampled. Checks the read
  // address sequence and returns the cycle in which done was seen (-1 on
  // timeout, 0 when aborted by reset).
  task automatic wait_done(input int restart_at, input int reset_at, output int done_n);
    logic [11:0] exp_addr;
    int j;
    done_n = -1;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        done_n = n;
        return;
      end
      j = (n - 1) / 4;
      if (n <= 20 && ((n - 1) % 4) < 2) begin
        exp_addr = ((n - 1) % 4 == 0) ? 12'(j + 1) : 12'(10 - j);
        n_tests++;
        if (aAddr !== exp_addr) begin
          n_fail++;
          $display("FAIL addr_seq cycle %0d: got %0d expected %0d", n, aAddr, exp_addr);
        end
      end
      start = (n == restart_at);
      reset = (n == reset_at);
      @(posedge clk); #1;
      start = 1'b0;
      if (n == reset_at) begin
        reset  = 1'b0;
        done_n = 0;
        return;
      end
    end
  endtask

  // Full operation on the current memory contents, with optional re-pulse.
  task automatic run_and_check(input string name, input int restart_at);
    int dn;
    logic [95:0] e1, e2;
    push_expected();
    kick();
    wait_done(restart_at, -1, dn);
    n_tests++;
    if (dn != 21) begin
      n_fail++;
      $display("FAIL %s latency: got cycle %0d expected 21", name, dn);
    end
    e1 = q_f1.pop_front();
    e2 = q_f2.pop_front();
    n_tests++;
    if (f1Out !== e1) begin
      n_fail++;
      $display("FAIL %s f1: got %h expected %h", name, f1Out, e1);
    end
    n_tests++;
    if (f2Out !== e2) begin
      n_fail++;
      $display("FAIL %s f2: got %h expected %h", name, f2Out, e2);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || f1Out !== e1 || f2Out !== e2) begin
      n_fail++;
      $display("FAIL %s hold: done %b f1 %h f2 %h expected done 0 f1 %h f2 %h",
               name, done, f1Out, f2Out, e1, e2);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    n_tests++;
    if (f1Out !== 96'h0 || f2Out !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_coeffs: got f1 %h f2 %h expected 0", f1Out, f2Out);
    end
    n_tests++;
    if (done !== 1'b0 || aAddr !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got done %b addr %h expected 0 0", done, aAddr);
    end
    n_tests++;
    if ({L_multOutA, L_multOutB, L_macOutA, L_macOutB, L_macOutC, L_msuOutA, L_msuOutB,
         L_msuOutC, addOutA, addOutB, subOutA, subOutB} !== '0) begin
      n_fail++;
      $display("FAIL reset_ops: operator outputs not zero");
    end
    // start coincident with reset must not have been taken
    @(posedge clk); #1;
    n_tests++;
    if (aAddr !== 12'h0 || f1Out !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_wins: got addr %h f1 %h expected 0 0", aAddr, f1Out);
    end
  endtask

  task automatic test_zero();
    clear_mem();
    run_and_check("zero", -1);
    n_tests++;
    if (f1Out !== {16'hF800, 16'h0800, 16'hF800, 16'h0800, 16'hF800, 16'h0800} ||
        f2Out !== {6{16'h0800}}) begin
      n_fail++;
      $display("FAIL zero_const: got f1 %h f2 %h", f1Out, f2Out);
    end
  endtask

  task automatic test_sym4096();
    clear_mem();
    mem[1]  = 16'd4096;
    mem[10] = 16'd4096;
    run_and_check("sym4096", -1);
    n_tests++;
    if (f1Out !== {16'h0800, 16'hF800, 16'h0800, 16'hF800, 16'h0800, 16'h0800} ||
        f2Out !== {6{16'h0800}}) begin
      n_fail++;
      $display("FAIL sym4096_const: got f1 %h f2 %h", f1Out, f2Out);
    end
  endtask

  task automatic test_saturate();
    clear_mem();
    mem[1]  = 16'h8000;
    mem[10] = 16'h8000;
    run_and_check("saturate", -1);
    n_tests++;
    if (f1Out[31:16] !== 16'h8000 || f2Out[31:16] !== 16'h0800) begin
      n_fail++;
      $display("FAIL saturate_const: got f1[1] %h f2[1] %h expected 8000 0800",
               f1Out[31:16], f2Out[31:16]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 10; k++) mem[k] = 16'($urandom);
      run_and_check("random", -1);
    end
  endtask

  task automatic test_start_ignored();
    for (int k = 1; k <= 10; k++) mem[k] = 16'($urandom_range(0, 16'hFFFF));
    run_and_check("restart_ignored", 5);
  endtask

  task automatic test_reset_mid();
    int dn;
    int seen;
    for (int k = 1; k <= 10; k++) mem[k] = 16'($urandom);
    push_expected();
    kick();
    wait_done(-1, 10, dn);
    void'(q_f1.pop_front());
    void'(q_f2.pop_front());
    n_tests++;
    if (dn != 0 || f1Out !== 96'h0 || f2Out !== 96'h0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got dn %0d f1 %h f2 %h done %b expected 0 0 0 0",
               dn, f1Out, f2Out, done);
    end
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_nodone: got %0d done pulses expected 0", seen);
    end
    run_and_check("after_reset", -1);
  endtask

  task automatic test_back_to_back();
    int dn;
    logic [95:0] e1, e2;
    clear_mem();
    mem[2] = 16'd1000;
    mem[9] = 16'hF000;
    push_expected();
    kick();
    wait_done(-1, -1, dn);
    e1 = q_f1.pop_front();
    e2 = q_f2.pop_front();
    n_tests++;
    if (dn != 21 || f1Out !== e1 || f2Out !== e2) begin
      n_fail++;
      $display("FAIL b2b_first: got dn %0d f1 %h f2 %h expected 21 %h %h",
               dn, f1Out, f2Out, e1, e2);
    end
    // cycle after done: back in IDLE, start accepted immediately
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) mem[k] = 16'($urandom);
    push_expected();
    kick();
    n_tests++;
    if (f1Out !== {80'h0, 16'h0800} || f2Out !== {80'h0, 16'h0800}) begin
      n_fail++;
      $display("FAIL b2b_reload: got f1 %h f2 %h expected seed only", f1Out, f2Out);
    end
    wait_done(-1, -1, dn);
    e1 = q_f1.pop_front();
    e2 = q_f2.pop_front();
    n_tests++;
    if (dn != 21 || f1Out !== e1 || f2Out !== e2) begin
      n_fail++;
      $display("FAIL b2b_second: got dn %0d f1 %h f2 %h expected 21 %h %h",
               dn, f1Out, f2Out, e1, e2);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    start   = 1'b0;
    reset   = 1'b1;
    for (int k = 0; k < 4096; k++) mem[k] = 16'h0000;
    mem[0] = 16'h1000;  // a[0] is never used by the algorithm

    test_reset();
    test_zero();
    test_sym4096();
    test_saturate();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_az_sum_diff_poly
`default_nettype wire
